// File: rtl/watch_pkg.sv
// Shared encodings, field widths and limits for the watch mode/set controller.
package watch_pkg;

    localparam int unsigned YEAR_W  = 12;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned HOUR_W  = 6;
    localparam int unsigned MINUTE_W = 6;
    localparam int unsigned SECOND_W = 6;
    localparam int unsigned FLD_W   = 3;

    localparam int unsigned HOUR_MAX  = 23;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MONTH_MAX = 12;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [FLD_W-1:0] FLD_HOUR  = 3'd0;
    localparam logic [FLD_W-1:0] FLD_MIN   = 3'd1;
    localparam logic [FLD_W-1:0] FLD_SEC   = 3'd2;
    localparam logic [FLD_W-1:0] FLD_YEAR  = 3'd3;
    localparam logic [FLD_W-1:0] FLD_MONTH = 3'd4;
    localparam logic [FLD_W-1:0] FLD_DAY   = 3'd5;

    // Full time-of-day/calendar value as seen by the counter.
    typedef struct packed {
        logic [YEAR_W-1:0]   year;
        logic [MONTH_W-1:0]  month;
        logic [DAY_W-1:0]    day;
        logic [HOUR_W-1:0]   hour;
        logic [MINUTE_W-1:0] minute;
        logic [SECOND_W-1:0] second;
    } tod_t;

    // Field selection order HOUR->MIN->SEC->YEAR->MONTH->DAY->HOUR.
    function automatic logic [FLD_W-1:0] next_field(input logic [FLD_W-1:0] f);
        return (f >= FLD_DAY) ? FLD_HOUR : f + FLD_W'(1);
    endfunction

endpackage

// File: rtl/wrap_inc.sv
// Wrapping incrementer: values at MAX or outside [MIN, MAX] go to MIN.
module wrap_inc #(
    parameter int unsigned W   = 8,
    parameter int unsigned MIN = 0,
    parameter int unsigned MAX = 255
) (
    input  logic [W-1:0] val,
    output logic [W-1:0] nxt_c
);

    localparam logic [W-1:0] MIN_V = W'(MIN);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    // A zero minimum needs no lower-bound check on an unsigned value.
    generate
        if (MIN == 0) begin : g_zero_min
            assign nxt_c = (val >= MAX_V) ? MIN_V : val + W'(1);
        end else begin : g_nonzero_min
            assign nxt_c = ((val >= MAX_V) || (val < MIN_V)) ? MIN_V : val + W'(1);
        end
    endgenerate

endmodule

// File: rtl/watch_set_ctrl.sv
// Mode/set controller: freezes the time counter, edits a shadow copy field by field,
// and commits it back with a one-cycle load strobe.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned YEAR_MIN       = 2021,
    parameter int unsigned YEAR_MAX       = 2099,
    parameter int unsigned DAYS_PER_MONTH = 30,
    parameter int unsigned TIMEOUT_S      = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_1hz,
    input  logic                btn_mode,
    input  logic                btn_sel,
    input  logic                btn_inc,
    input  logic [YEAR_W-1:0]   cur_year,
    input  logic [MONTH_W-1:0]  cur_month,
    input  logic [DAY_W-1:0]    cur_day,
    input  logic [HOUR_W-1:0]   cur_hour,
    input  logic [MINUTE_W-1:0] cur_minute,
    input  logic [SECOND_W-1:0] cur_second,
    output logic                run_en,
    output logic                load,
    output logic [YEAR_W-1:0]   ld_year,
    output logic [MONTH_W-1:0]  ld_month,
    output logic [DAY_W-1:0]    ld_day,
    output logic [HOUR_W-1:0]   ld_hour,
    output logic [MINUTE_W-1:0] ld_minute,
    output logic [SECOND_W-1:0] ld_second,
    output logic [FLD_W-1:0]    edit_field,
    output logic                editing,
    output logic                blink
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_S + 1);

    state_t           state, state_nx;
    tod_t             shadow, shadow_nx, cur_c;
    logic [FLD_W-1:0] field_nx;
    logic [TMO_W-1:0] tmo, tmo_nx;
    logic             blink_nx, run_en_nx, load_nx, editing_nx;
    logic             sel_act, inc_act;

    logic [YEAR_W-1:0]   year_inc_c;
    logic [MONTH_W-1:0]  month_inc_c;
    logic [DAY_W-1:0]    day_inc_c;
    logic [HOUR_W-1:0]   hour_inc_c;
    logic [MINUTE_W-1:0] minute_inc_c;
    logic [SECOND_W-1:0] second_inc_c;

    assign cur_c = '{year: cur_year, month: cur_month, day: cur_day,
                     hour: cur_hour, minute: cur_minute, second: cur_second};

    // Button priority mode > sel > inc.
    assign sel_act = btn_sel && !btn_mode;
    assign inc_act = btn_inc && !btn_mode && !btn_sel;

    wrap_inc #(.W(YEAR_W),   .MIN(YEAR_MIN), .MAX(YEAR_MAX))       u_year   (.val(shadow.year),   .nxt_c(year_inc_c));
    wrap_inc #(.W(MONTH_W),  .MIN(1),        .MAX(MONTH_MAX))      u_month  (.val(shadow.month),  .nxt_c(month_inc_c));
    wrap_inc #(.W(DAY_W),    .MIN(1),        .MAX(DAYS_PER_MONTH)) u_day    (.val(shadow.day),    .nxt_c(day_inc_c));
    wrap_inc #(.W(HOUR_W),   .MIN(0),        .MAX(HOUR_MAX))       u_hour   (.val(shadow.hour),   .nxt_c(hour_inc_c));
    wrap_inc #(.W(MINUTE_W), .MIN(0),        .MAX(MIN_MAX))        u_minute (.val(shadow.minute), .nxt_c(minute_inc_c));
    wrap_inc #(.W(SECOND_W), .MIN(0),        .MAX(SEC_MAX))        u_second (.val(shadow.second), .nxt_c(second_inc_c));

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            shadow     <= '{year: YEAR_W'(YEAR_MIN), month: MONTH_W'(1), day: DAY_W'(1),
                            hour: '0, minute: '0, second: '0};
            edit_field <= FLD_HOUR;
            tmo        <= '0;
            blink      <= 1'b0;
            run_en     <= 1'b1;
            load       <= 1'b0;
            editing    <= 1'b0;
        end else begin
            state      <= state_nx;
            shadow     <= shadow_nx;
            edit_field <= field_nx;
            tmo        <= tmo_nx;
            blink      <= blink_nx;
            run_en     <= run_en_nx;
            load       <= load_nx;
            editing    <= editing_nx;
        end
    end

    // Next state, shadow updates and next output values.
    always_comb begin
        state_nx   = state;
        shadow_nx  = shadow;
        field_nx   = edit_field;
        tmo_nx     = tmo;
        blink_nx   = blink;
        run_en_nx  = 1'b1;
        load_nx    = 1'b0;
        editing_nx = 1'b0;

        case (state)
            RUN: begin
                if (btn_mode) begin
                    state_nx  = EDIT;
                    shadow_nx = cur_c;
                    field_nx  = FLD_HOUR;
                    tmo_nx    = '0;
                    blink_nx  = 1'b1;
                end
            end
            EDIT: begin
                if (btn_mode) begin
                    state_nx = COMMIT;
                end else begin
                    if (tick_1hz) blink_nx = ~blink;
                    if (sel_act) begin
                        field_nx = next_field(edit_field);
                        blink_nx = 1'b1;
                    end
                    if (inc_act) begin
                        blink_nx = 1'b1;
                        case (edit_field)
                            FLD_HOUR:  shadow_nx.hour   = hour_inc_c;
                            FLD_MIN:   shadow_nx.minute = minute_inc_c;
                            FLD_SEC:   shadow_nx.second = second_inc_c;
                            FLD_YEAR:  shadow_nx.year   = year_inc_c;
                            FLD_MONTH: shadow_nx.month  = month_inc_c;
                            FLD_DAY:   shadow_nx.day    = day_inc_c;
                            default:   ;
                        endcase
                    end
                    // Any button press restarts the inactivity window.
                    if (btn_sel || btn_inc) begin
                        tmo_nx = '0;
                    end else if (tick_1hz) begin
                        if (tmo >= TMO_W'(TIMEOUT_S - 1)) begin
                            state_nx = RUN;
                            tmo_nx   = '0;
                        end else begin
                            tmo_nx = tmo + TMO_W'(1);
                        end
                    end
                end
            end
            COMMIT:  state_nx = RUN;
            default: state_nx = RUN;
        endcase

        case (state_nx)
            EDIT: begin
                run_en_nx  = 1'b0;
                editing_nx = 1'b1;
            end
            COMMIT: begin
                run_en_nx = 1'b0;
                load_nx   = 1'b1;
            end
            default: ;
        endcase
        if (state_nx != EDIT) blink_nx = 1'b0;
    end

    assign ld_year   = shadow.year;
    assign ld_month  = shadow.month;
    assign ld_day    = shadow.day;
    assign ld_hour   = shadow.hour;
    assign ld_minute = shadow.minute;
    assign ld_second = shadow.second;

endmodule
